// File: rtl/w8_pkg.sv
// Shared constants and types for the w8 weight loader.
package w8_pkg;

    localparam int unsigned NBANK     = 16;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned AW        = 4;
    localparam int unsigned DW        = 8;
    localparam int unsigned IMG_BYTES = 256;
    localparam int unsigned CW        = 8;

    typedef logic signed [DW-1:0] weight_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFlush,
        StKick,
        StWait
    } state_e;

endpackage

// File: rtl/w8_bank_wr.sv
// Registered write port for the 16 weight banks: one-hot bank decode of the
// beat index upper nibble, shared address/data registers.
module w8_bank_wr
    import w8_pkg::*;
(
    input  logic             clk,
    input  logic             xrst,
    input  logic             wr_en,
    input  logic [CW-1:0]    idx,
    input  weight_t          data,
    output logic [NBANK-1:0] w_we,
    output logic [AW-1:0]    w_waddr,
    output weight_t          w_wdata
);

    logic [NBANK-1:0] onehot;

    // Bank-major layout: beat index [7:4] picks the bank, [3:0] the entry.
    always_comb begin
        onehot = {{(NBANK-1){1'b0}}, 1'b1} << idx[7:4];
    end

    // Write enable lives for one cycle; address/data hold between writes.
    always_ff @(posedge clk) begin
        if (xrst) begin
            w_we    <= '0;
            w_waddr <= '0;
            w_wdata <= '0;
        end else begin
            w_we <= wr_en ? onehot : '0;
            if (wr_en) begin
                w_waddr <= idx[3:0];
                w_wdata <= data;
            end
        end
    end

endmodule

// File: rtl/w8_weight_loader.sv
// Streams a 256-byte weight image into the w8 banks, then kicks w8 and waits
// for its completion. Optional checksum output: W8_LOADER_CHECKSUM_EN.
module w8_weight_loader
    import w8_pkg::*;
(
    input  logic             clk,
    input  logic             xrst,
    input  logic             load_req,
    input  logic             s_valid,
    output logic             s_ready,
    input  weight_t          s_data,
    input  logic             s_last,
    output logic [NBANK-1:0] w_we,
    output logic [AW-1:0]    w_waddr,
    output weight_t          w_wdata,
    output logic             start,
    input  logic             finish,
    output logic             done,
    output logic             busy,
`ifdef W8_LOADER_CHECKSUM_EN
    output logic [15:0]      csum,
`endif
    output logic             err
);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q;
    logic          err_q;
    logic          done_q;
    logic          accept;
    logic          is_last_beat;
    logic          frame_bad;
    logic          enter_load;

    assign accept       = s_valid && (state_q == StLoad);
    assign is_last_beat = (count_q == CW'(IMG_BYTES - 1));
    // s_last must appear exactly on the final beat, nowhere else.
    assign frame_bad    = s_last ^ is_last_beat;
    assign enter_load   = (state_q == StIdle) && load_req;

    // Next-state and Moore outputs.
    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_req) state_d = StLoad;
            end
            StLoad: begin
                s_ready = 1'b1;
                if (s_valid && is_last_beat) state_d = StFlush;
            end
            StFlush: state_d = StKick;
            StKick: begin
                start   = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                // finish beats any concurrent load_req; load_req is not looked at here.
                if (finish) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, beat counter, sticky framing error and done pulse.
    always_ff @(posedge clk) begin
        if (xrst) begin
            state_q <= StIdle;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == StWait) && finish;
            if (enter_load) begin
                count_q <= '0;
                err_q   <= 1'b0;
            end else if (accept) begin
                if (!is_last_beat) count_q <= count_q + CW'(1);
                if (frame_bad) err_q <= 1'b1;
            end
        end
    end

    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q != StIdle);

    w8_bank_wr u_bank_wr (
        .clk     (clk),
        .xrst    (xrst),
        .wr_en   (accept),
        .idx     (count_q),
        .data    (s_data),
        .w_we    (w_we),
        .w_waddr (w_waddr),
        .w_wdata (w_wdata)
    );

`ifdef W8_LOADER_CHECKSUM_EN
    logic [15:0] csum_q;

    // Running sum of sign-extended accepted bytes for the current load.
    always_ff @(posedge clk) begin
        if (xrst) begin
            csum_q <= '0;
        end else if (enter_load) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q + {{(16 - DW){s_data[DW-1]}}, s_data};
        end
    end

    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_w8_weight_loader.sv
// Self-checking bench for w8_weight_loader: table of load scenarios plus
// hand-written reset / idle-finish sequences, with a write scoreboard.
module tb_w8_weight_loader;

    logic        clk = 1'b0;
    logic        xrst;
    logic        load_req;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [15:0] w_we;
    logic [3:0]  w_waddr;
    logic [7:0]  w_wdata;
    logic        start;
    logic        finish;
    logic        done;
    logic        busy;
    logic        err;
`ifdef W8_LOADER_CHECKSUM_EN
    logic [15:0] csum;
`endif

    always #5 clk = ~clk;

    w8_weight_loader dut (
        .clk      (clk),
        .xrst     (xrst),
        .load_req (load_req),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .w_we     (w_we),
        .w_waddr  (w_waddr),
        .w_wdata  (w_wdata),
        .start    (start),
        .finish   (finish),
        .done     (done),
        .busy     (busy),
`ifdef W8_LOADER_CHECKSUM_EN
        .csum     (csum),
`endif
        .err      (err)
    );

    typedef struct {
        logic [15:0] we;
        logic [3:0]  addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    typedef struct {
        int         gap_pct;
        int         last_idx;
        logic [7:0] mask;
        int         fin_dly;
        bit         simul_req;
        bit         exp_err;
    } vec_t;

    wr_t        q[$];
    logic [7:0] mem[16][16];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int sum = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] beat_data(input int k, input logic [7:0] mask, input bit c80);
        logic [7:0] kb;
        kb = k[7:0];
        return c80 ? 8'h80 : (kb ^ mask);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write must match the oldest accepted beat, one cycle later.
    always @(negedge clk) begin
        if (start) start_cnt++;
        if (done) done_cnt++;
        if (w_we != 16'h0) begin
            we_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_write", w_we, 32'h0);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("w_we", w_we, e.we);
                chk("w_waddr", w_waddr, e.addr);
                chk("w_wdata", w_wdata, e.data);
                chk("write_latency", cyc, e.cyc + 1);
                for (int b = 0; b < 16; b++) if (w_we[b]) mem[b][w_waddr] = w_wdata;
            end
        end
    end

    task automatic idle_inputs();
        load_req = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        s_last   = 1'b0;
        finish   = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_w_we"}, w_we, 0);
        chk({tag, "_w_waddr"}, w_waddr, 0);
        chk({tag, "_w_wdata"}, w_wdata, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // One full load: stream 256 beats, wait for start, drive finish, check done.
    task automatic run_load(input vec_t v, input bit c80);
        int k, guard, last_cyc, g, bad, d;
        bit vld, err_pending;
        logic signed [7:0] sb;
        we_cnt = 0; start_cnt = 0; done_cnt = 0; sum = 0; err_pending = 0; last_cyc = 0;
        for (int b = 0; b < 16; b++) for (int a = 0; a < 16; a++) mem[b][a] = 8'hxx;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("busy_after_req", busy, 1);
        chk("err_cleared_by_req", err, 0);
        chk("s_ready_in_load", s_ready, 1);
        k = 0; guard = 0;
        while (k < 256 && guard < 3000) begin
            guard++;
            vld = ($urandom_range(99) >= v.gap_pct);
            s_valid = vld;
            s_data  = beat_data(k, v.mask, c80);
            s_last  = (k == v.last_idx);
            if (err_pending) begin
                chk("err_after_bad_last", err, 1);
                err_pending = 0;
            end
            if (vld && s_ready) begin
                q.push_back('{we: 16'h1 << k[7:4], addr: k[3:0], data: s_data, cyc: cyc});
                sb = s_data;
                sum += int'(sb);
                if (k == v.last_idx && k != 255) err_pending = 1;
                if (k == 255) last_cyc = cyc;
                k++;
            end
            @(negedge clk);
        end
        chk("beats_accepted", k, 256);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("s_ready_drops", s_ready, 0);
        g = 0;
        while (!start && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk("start_seen", start, 1);
        chk("start_latency", cyc - last_cyc, 2);
        chk("err_final", err, v.exp_err);
        chk("we_pulses", we_cnt, 256);
        chk("queue_drained", q.size(), 0);
        bad = 0;
        for (int b = 0; b < 16; b++)
            for (int a = 0; a < 16; a++)
                if (mem[b][a] !== beat_data(16 * b + a, v.mask, c80)) bad++;
        chk("bank_contents", bad, 0);
`ifdef W8_LOADER_CHECKSUM_EN
        chk("csum", csum, sum[15:0]);
`endif
        d = v.fin_dly;
        if (d == 0) begin
            // finish during the start cycle must be ignored
            finish = 1'b1;
            @(negedge clk);
            finish = 1'b0;
            chk("finish_in_kick_ignored_done", done, 0);
            chk("finish_in_kick_ignored_busy", busy, 1);
            d = 5;
            repeat (d - 1) @(negedge clk);
        end else begin
            repeat (d) @(negedge clk);
        end
        chk("no_early_done", done, 0);
        chk("busy_in_wait", busy, 1);
        finish   = 1'b1;
        load_req = v.simul_req;
        @(negedge clk);
        finish   = 1'b0;
        load_req = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_with_done", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        chk("start_count", start_cnt, 1);
        chk("done_count", done_cnt, 1);
    endtask

    vec_t vecs[5];

    initial begin
        int k;
        vecs[0] = '{gap_pct: 0,  last_idx: 255, mask: 8'h00, fin_dly: 10, simul_req: 0, exp_err: 0};
        vecs[1] = '{gap_pct: 40, last_idx: 255, mask: 8'h00, fin_dly: 3,  simul_req: 0, exp_err: 0};
        vecs[2] = '{gap_pct: 30, last_idx: 100, mask: 8'h5a, fin_dly: 10, simul_req: 0, exp_err: 1};
        vecs[3] = '{gap_pct: 10, last_idx: 255, mask: 8'hc3, fin_dly: 0,  simul_req: 1, exp_err: 0};
        vecs[4] = '{gap_pct: 20, last_idx: 300, mask: 8'h33, fin_dly: 7,  simul_req: 0, exp_err: 1};

        idle_inputs();
        xrst = 1'b1;
        repeat (3) @(negedge clk);
        xrst = 1'b0;
        @(negedge clk);
        check_quiet("reset");

        for (int i = 0; i < 5; i++) run_load(vecs[i], 1'b0);

        // finish while idle must not produce done
        done_cnt = 0;
        finish = 1'b1;
        repeat (2) @(negedge clk);
        finish = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_finish_no_done", done_cnt, 0);
        chk("idle_finish_busy", busy, 0);

        // reset in the middle of a load
        start_cnt = 0;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        k = 0;
        while (k < 130) begin
            s_valid = 1'b1;
            s_data  = beat_data(k, 8'h00, 1'b0);
            s_last  = 1'b0;
            if (s_ready) begin
                q.push_back('{we: 16'h1 << k[7:4], addr: k[3:0], data: s_data, cyc: cyc});
                k++;
            end else begin
                k = 130;
                chk("ready_before_reset", s_ready, 1);
            end
            @(negedge clk);
        end
        xrst    = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        xrst = 1'b0;
        check_quiet("midload_reset");
        repeat (20) @(negedge clk);
        chk("no_start_after_reset", start_cnt, 0);
        chk("queue_after_reset", q.size(), 0);
        q.delete();

        run_load(vecs[0], 1'b0);
`ifdef W8_LOADER_CHECKSUM_EN
        run_load(vecs[0], 1'b1);
        chk("csum_all_80", csum, 16'h8000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/w8_weight_loader.md
Name: w8_weight_loader

Overview:
- Upstream feeder for the w8 compute stage.
- Accepts a byte stream of signed 8-bit weights over a valid/ready handshake and writes them into the 16 weight banks (16 entries x 8 bits each) that w8 reads.
- After the full 256-byte image is written, pulses start to w8, waits for its finish, then reports done.

Parameters:
- NBANK, 16, number of weight banks (one-hot write enable width).
- DEPTH, 16, entries per bank.
- AW, 4, bank address width (log2 DEPTH).
- DW, 8, weight width (signed).

Ports:
- clk  input  1  clock
- xrst  input  1  reset, synchronous, active-high
- load_req  input  1  one-cycle request to begin a load; honoured only in IDLE
- s_valid  input  1  stream beat valid
- s_ready  output  1  stream beat accepted when s_valid & s_ready
- s_data  input  DW  signed weight byte
- s_last  input  1  marks final beat of image
- w_we  output  NBANK  one-hot bank write enable
- w_waddr  output  AW  write address, shared by all banks
- w_wdata  output  DW  write data, shared by all banks
- start  output  1  one-cycle pulse to w8
- finish  input  1  completion from w8
- done  output  1  one-cycle pulse when w8 finishes
- busy  output  1  high in any state except IDLE
- err  output  1  sticky framing error; cleared by reset or by an accepted load_req

Behaviour:
- Reset: synchronous, active-high on xrst. State=IDLE; count=0; s_ready, w_we, w_waddr, w_wdata, start, done, busy, err all 0.
- Reset mid-load or mid-wait aborts immediately. No start/done is emitted.
- FSM states: IDLE, LOAD, FLUSH, KICK, WAIT.
- IDLE:
  - load_req=1 -> LOAD; count=0; err cleared.
  - finish is ignored.
- LOAD:
  - s_ready=1.
  - Each accepted beat k (0..255) writes bank k[7:4], address k[3:0]. Bank-major order: bytes 0-15 go to bank 0.
  - Write is registered: beat accepted in cycle t gives w_we one-hot, w_waddr, w_wdata valid in cycle t+1, for one cycle only.
  - w_we=0 in all other cycles.
  - Beat k=255 accepted -> FLUSH; s_ready drops in the next cycle.
  - count is 8 bits and does not wrap within a load.
- Framing:
  - s_last=1 on beat k<255 -> err=1. The beat is still written; the load continues to 256 beats.
  - s_last=0 on beat 255 -> err=1.
  - err does not block start.
- FLUSH: one cycle, covering the final write. -> KICK.
- KICK: start=1 for exactly one cycle. -> WAIT.
  - Latency: last beat accepted at t gives last write at t+1 and start at t+2.
- WAIT:
  - s_ready=0; load_req ignored.
  - finish=1 sampled -> done=1 in the next cycle, state=IDLE in that same cycle.
  - finish sampled in the same cycle start is high is not honoured; finish is only sampled in WAIT.
- Simultaneous load_req and finish in WAIT: finish wins; load_req is dropped.
- No backpressure toward the banks; they are assumed single-cycle writable.

Optional Feature:
- Macro: W8_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output csum [15:0], the two's-complement sum of all sign-extended bytes accepted in the current load.
  - Cleared on reset and when LOAD is entered.
  - Updated in the cycle after each accepted beat; stable from FLUSH until the next load.
- Undefined: no csum port and no adder logic.

Decomposition:
- Package w8_pkg:
  - constants NBANK, DEPTH, AW, DW, IMG_BYTES=256;
  - enum typedef for FSM states;
  - typedef for the signed weight type.
- The write-port register stage (one-hot decode of count[7:4] plus address/data registers) is a natural sub-module: w8_bank_wr.
- FSM and counter stay in the top module.

Test Plan:
- Reset, then load_req, then 256 beats with s_valid held high and s_last on beat 255:
  - bank b address a receives byte 16b+a;
  - start pulses exactly once, 2 cycles after the last beat;
  - err=0.
- Random s_valid gaps during LOAD: the write sequence and the final bank contents are identical to the back-to-back case; w_we pulses exactly 256 times.
- s_last asserted on beat 100 -> err=1 from the next cycle; all 256 beats are still written; start still pulses; a new load_req clears err.
- finish asserted 10 cycles after start -> done pulses 1 cycle later; busy=0 in that same cycle; a second finish in IDLE produces no done.
- xrst asserted at beat 130 -> all outputs return to 0; no start follows; a fresh load completes normally.
- With W8_LOADER_CHECKSUM_EN defined and all 256 bytes set to 8'h80 (-128) -> csum=16'h8000.
